// File: rtl/pipe_pkg.sv
// Shared encodings and types for the MIPS pipeline hazard controller.
package pipe_pkg;

    localparam logic [1:0] SDW_ALU = 2'b00;
    localparam logic [1:0] SDW_MEM = 2'b01;
    localparam logic [1:0] SDW_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {RUN, WAIT} state_t;

    // $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// EXE-stage operand forwarding selects; MEM results take priority over WB.
module forward_unit
    import pipe_pkg::*;
(
    input  logic [4:0] exe_rs,
    input  logic [4:0] exe_rt,
    input  logic [4:0] mem_num_write,
    input  logic       mem_reg_write,
    input  logic [1:0] mem_s_data_write,
    input  logic [4:0] wb_num_write,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // A load in MEM has no data yet; the load-use stall covers that case.
    function automatic logic [1:0] select(input logic [4:0] src);
        if (mem_reg_write && (mem_s_data_write != SDW_MEM) && reg_match(mem_num_write, src))
            return FWD_MEM;
        else if (wb_reg_write && reg_match(wb_num_write, src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = select(exe_rs);
        fwd_b = select(exe_rt);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, branch flush, load-use stall,
// forwarding selects and saturating performance counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255,
    parameter int         CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic [4:0]       EXE_rs,
    input  logic [4:0]       EXE_rt,
    input  logic [4:0]       EXE_num_write,
    input  logic             EXE_reg_write,
    input  logic [1:0]       EXE_s_data_write,
    input  logic             EXE_branch_taken,
    input  logic [4:0]       MEM_num_write,
    input  logic             MEM_reg_write,
    input  logic [1:0]       MEM_s_data_write,
    input  logic [4:0]       WB_num_write,
    input  logic             WB_reg_write,
    input  logic             MEM_mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             IF_ID_en,
    output logic             ID_EXE_en,
    output logic             EXE_MEM_en,
    output logic             MEM_WB_en,
    output logic             IF_ID_flush,
    output logic             ID_EXE_flush,
    output logic             MEM_WB_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state, state_next;
    logic [7:0] wait_cnt;
    logic       freeze, timeout, load_use, stall_event, flush_event;

    forward_unit u_forward (
        .exe_rs           (EXE_rs),
        .exe_rt           (EXE_rt),
        .mem_num_write    (MEM_num_write),
        .mem_reg_write    (MEM_reg_write),
        .mem_s_data_write (MEM_s_data_write),
        .wb_num_write     (WB_num_write),
        .wb_reg_write     (WB_reg_write),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b)
    );

    always_comb begin
        freeze       = 1'b0;
        timeout      = 1'b0;
        state_next   = state;
        pc_en        = 1'b1;
        IF_ID_en     = 1'b1;
        ID_EXE_en    = 1'b1;
        EXE_MEM_en   = 1'b1;
        MEM_WB_en    = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EXE_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        stall_event  = 1'b0;
        flush_event  = 1'b0;

        load_use = EXE_reg_write && (EXE_s_data_write == SDW_MEM) &&
                   ((ID_use_rs && reg_match(ID_rs, EXE_num_write)) ||
                    (ID_use_rt && reg_match(ID_rt, EXE_num_write)));

        // A timed-out access leaves WAIT exactly as if memory had answered.
        case (state)
            RUN: begin
                freeze = MEM_mem_req && !mem_ready;
                if (freeze)
                    state_next = WAIT;
            end
            WAIT: begin
                timeout = !mem_ready && (wait_cnt == MEM_TIMEOUT);
                freeze  = !mem_ready && !timeout;
                if (!freeze)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase

        if (freeze) begin
            pc_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EXE_en    = 1'b0;
            EXE_MEM_en   = 1'b0;
            MEM_WB_flush = 1'b1;
            stall_event  = 1'b1;
        end else if (EXE_branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EXE_flush = 1'b1;
            flush_event  = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EXE_flush = 1'b1;
            stall_event  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == RUN)
                wait_cnt <= 8'd0;
            else if (freeze)
                wait_cnt <= wait_cnt + 8'd1;
            if (timeout)
                mem_err <= 1'b1;
            if (stall_event && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_event && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl: vector table plus
// hand-written multi-cycle sequences for stalls, memory waits and reset.
module tb_pipeline_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EXE_rs, EXE_rt, EXE_num_write, MEM_num_write, WB_num_write;
    logic        ID_use_rs, ID_use_rt, EXE_reg_write, EXE_branch_taken;
    logic        MEM_reg_write, WB_reg_write, MEM_mem_req, mem_ready;
    logic [1:0]  EXE_s_data_write, MEM_s_data_write;
    logic        pc_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en;
    logic        IF_ID_flush, ID_EXE_flush, MEM_WB_flush, mem_err;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;
    logic [11:0] outs;

    int checks   = 0;
    int failures = 0;

    localparam logic [11:0] IDLE   = 12'b11111_000_0000;
    localparam logic [11:0] FREEZE = 12'b00001_001_0000;
    localparam logic [11:0] LUSTL  = 12'b00111_010_0000;
    localparam logic [11:0] BRFL   = 12'b11111_110_0000;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(8'd4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
        .EXE_rs(EXE_rs), .EXE_rt(EXE_rt), .EXE_num_write(EXE_num_write),
        .EXE_reg_write(EXE_reg_write), .EXE_s_data_write(EXE_s_data_write),
        .EXE_branch_taken(EXE_branch_taken),
        .MEM_num_write(MEM_num_write), .MEM_reg_write(MEM_reg_write),
        .MEM_s_data_write(MEM_s_data_write),
        .WB_num_write(WB_num_write), .WB_reg_write(WB_reg_write),
        .MEM_mem_req(MEM_mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .IF_ID_en(IF_ID_en), .ID_EXE_en(ID_EXE_en),
        .EXE_MEM_en(EXE_MEM_en), .MEM_WB_en(MEM_WB_en),
        .IF_ID_flush(IF_ID_flush), .ID_EXE_flush(ID_EXE_flush), .MEM_WB_flush(MEM_WB_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    assign outs = {pc_en, IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en,
                   IF_ID_flush, ID_EXE_flush, MEM_WB_flush, fwd_a, fwd_b};

    typedef struct {
        string      name;
        logic [4:0] id_rs, id_rt;
        logic       use_rs, use_rt;
        logic [4:0] exe_rs, exe_rt, exe_nw;
        logic       exe_rw;
        logic [1:0] exe_sdw;
        logic       br;
        logic [4:0] mem_nw;
        logic       mem_rw;
        logic [1:0] mem_sdw;
        logic [4:0] wb_nw;
        logic       wb_rw;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ID_rs = 0; ID_rt = 0; ID_use_rs = 0; ID_use_rt = 0;
        EXE_rs = 0; EXE_rt = 0; EXE_num_write = 0; EXE_reg_write = 0;
        EXE_s_data_write = 2'b00; EXE_branch_taken = 0;
        MEM_num_write = 0; MEM_reg_write = 0; MEM_s_data_write = 2'b00;
        WB_num_write = 0; WB_reg_write = 0; MEM_mem_req = 0; mem_ready = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        ID_rs = v.id_rs; ID_rt = v.id_rt; ID_use_rs = v.use_rs; ID_use_rt = v.use_rt;
        EXE_rs = v.exe_rs; EXE_rt = v.exe_rt; EXE_num_write = v.exe_nw;
        EXE_reg_write = v.exe_rw; EXE_s_data_write = v.exe_sdw; EXE_branch_taken = v.br;
        MEM_num_write = v.mem_nw; MEM_reg_write = v.mem_rw; MEM_s_data_write = v.mem_sdw;
        WB_num_write = v.wb_nw; WB_reg_write = v.wb_rw;
        MEM_mem_req = 0; mem_ready = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        idle_inputs();
        reset = 0;
        #2;
        check("reset_cnt", {stall_cnt, flush_cnt}, 32'd0);
        @(negedge clock);
        reset = 1;
    endtask

    initial begin
        vecs[0]  = '{"idle",         0,0,0,0, 0,0,0,0,2'b00, 0, 0,0,2'b00, 0,0, IDLE};
        vecs[1]  = '{"lu_rs",        2,1,1,1, 0,0,2,1,2'b01, 0, 0,0,2'b00, 0,0, LUSTL};
        vecs[2]  = '{"lu_rt",        1,2,1,1, 0,0,2,1,2'b01, 0, 0,0,2'b00, 0,0, LUSTL};
        vecs[3]  = '{"lu_rt_unused", 1,2,1,0, 0,0,2,1,2'b01, 0, 0,0,2'b00, 0,0, IDLE};
        vecs[4]  = '{"alu_no_stall", 2,1,1,1, 0,0,2,1,2'b00, 0, 0,0,2'b00, 0,0, IDLE};
        vecs[5]  = '{"r0_no_stall",  0,0,1,1, 0,0,0,1,2'b01, 0, 0,0,2'b00, 0,0, IDLE};
        vecs[6]  = '{"lw_no_write",  2,1,1,1, 0,0,2,0,2'b01, 0, 0,0,2'b00, 0,0, IDLE};
        vecs[7]  = '{"br_over_lu",   2,1,1,1, 0,0,2,1,2'b01, 1, 0,0,2'b00, 0,0, BRFL};
        vecs[8]  = '{"fwd_mem",      0,0,0,0, 5,5,0,0,2'b00, 0, 5,1,2'b00, 5,1, 12'b11111_000_0101};
        vecs[9]  = '{"fwd_wb",       0,0,0,0, 5,5,0,0,2'b00, 0, 5,0,2'b00, 5,1, 12'b11111_000_1010};
        vecs[10] = '{"fwd_r0",       0,0,0,0, 0,0,0,0,2'b00, 0, 0,1,2'b00, 0,1, IDLE};
        vecs[11] = '{"fwd_mem_load", 0,0,0,0, 5,7,0,0,2'b00, 0, 5,1,2'b01, 5,1, 12'b11111_000_1000};
        vecs[12] = '{"fwd_pc4_wb",   0,0,0,0, 5,6,0,0,2'b00, 0, 5,1,2'b10, 6,1, 12'b11111_000_0110};

        idle_inputs();
        reset = 0;
        #2;
        check("reset_outs", outs, IDLE);
        check("reset_regs", {stall_cnt, flush_cnt, 15'd0, mem_err}, 32'd0);
        @(negedge clock);
        reset = 1;

        // Table: each vector held for exactly one clock.
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            apply_vec(vecs[i]);
            #2;
            check(vecs[i].name, outs, vecs[i].exp);
        end
        @(negedge clock);
        idle_inputs();
        #2;
        check("table_stall_cnt", stall_cnt, 16'd2);
        check("table_flush_cnt", flush_cnt, 16'd1);

        pulse_reset();

        // Load-use: one bubble, then the load sits in MEM.
        @(negedge clock);
        apply_vec(vecs[1]);
        #2;
        check("lu_seq_stall", outs, LUSTL);
        @(negedge clock);
        idle_inputs();
        ID_rs = 2; ID_use_rs = 1;
        MEM_num_write = 2; MEM_reg_write = 1; MEM_s_data_write = 2'b01;
        #2;
        check("lu_seq_next", outs, IDLE);
        check("lu_seq_stall_cnt", stall_cnt, 16'd1);

        // Branch overriding load-use.
        @(negedge clock);
        apply_vec(vecs[7]);
        #2;
        check("br_seq_outs", outs, BRFL);
        @(negedge clock);
        idle_inputs();
        #2;
        check("br_seq_flush_cnt", flush_cnt, 16'd1);
        check("br_seq_stall_cnt", stall_cnt, 16'd1);

        // Memory wait: 3 freeze cycles, branch during a freeze is held.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            idle_inputs();
            MEM_mem_req = 1;
            EXE_branch_taken = (i == 1);
            #2;
            check($sformatf("mem_wait_freeze%0d", i), outs, FREEZE);
        end
        @(negedge clock);
        idle_inputs();
        MEM_mem_req = 1; mem_ready = 1;
        #2;
        check("mem_wait_ready", outs, IDLE);
        @(negedge clock);
        idle_inputs();
        #2;
        check("mem_wait_idle", outs, IDLE);
        check("mem_wait_stall_cnt", stall_cnt, 16'd4);
        check("mem_wait_flush_cnt", flush_cnt, 16'd1);

        // Ready in the request cycle: no freeze, no WAIT visit.
        @(negedge clock);
        MEM_mem_req = 1; mem_ready = 1;
        #2;
        check("mem_fast_outs", outs, IDLE);
        @(negedge clock);
        idle_inputs();
        #2;
        check("mem_fast_no_wait", outs, IDLE);
        check("mem_fast_stall_cnt", stall_cnt, 16'd4);

        // Timeout: 1 RUN freeze + WAIT counts 0..3, exit when count hits 4.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            idle_inputs();
            MEM_mem_req = 1;
            #2;
            check($sformatf("to_freeze%0d", i), {mem_err, outs}, {1'b0, FREEZE});
        end
        @(negedge clock);
        #2;
        check("to_exit_cycle", outs, IDLE);
        @(negedge clock);
        idle_inputs();
        #2;
        check("to_mem_err", mem_err, 1'b1);
        check("to_outs_after", outs, IDLE);
        check("to_stall_cnt", stall_cnt, 16'd9);
        @(negedge clock);
        #2;
        check("to_mem_err_sticky", mem_err, 1'b1);

        // Reset mid-WAIT: WAIT freezes even with the request dropped.
        @(negedge clock);
        MEM_mem_req = 1;
        @(negedge clock);
        MEM_mem_req = 0;
        #2;
        check("rst_wait_frozen", outs, FREEZE);
        #1;
        reset = 0;
        #1;
        check("rst_wait_outs", outs, IDLE);
        check("rst_wait_regs", {stall_cnt, flush_cnt, 15'd0, mem_err}, 32'd0);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        #2;
        check("rst_wait_after", outs, IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
